// File: rtl/accel_axis_scheduler.sv
// Purpose: sequences the SPI accelerometer reader across X/Y/Z and keeps a per-axis snapshot bank fresh.
// Latency: SELECT + SETTLE_CYCLES + DISCARD strobes + 1 capture strobe per slot; host ack 1 clk after capture.
// Backpressure: none; one host request held at a time, further requests dropped until it is acked.
module accel_axis_scheduler #(
  parameter int SETTLE_CYCLES = 100,  // must be >= 1
  parameter int DISCARD       = 1,
  parameter int TIMEOUT       = 50000 // must be >= 1
) (
  input  logic        iCLK,
  input  logic        iRSTN,
  input  logic        iEN,
  input  logic [15:0] iSAMPLE,
  input  logic        iSAMPLE_STB,
  output logic [1:0]  oDIMENSION,
  input  logic        iHOST_REQ,
  input  logic [1:0]  iHOST_AXIS,
  output logic        oHOST_ACK,
  output logic [15:0] oHOST_DATA,
  output logic [15:0] oAXIS_X,
  output logic [15:0] oAXIS_Y,
  output logic [15:0] oAXIS_Z,
  output logic [2:0]  oFRESH,
  output logic        oTIMEOUT
);

  // Counters only need to reach their last value (N-1).
  localparam int SET_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int DIS_W  = (DISCARD > 1) ? $clog2(DISCARD) : 1;
  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [DIS_W-1:0]  DIS_LAST  = DIS_W'(DISCARD - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SELECT  = 3'd1,
    S_SETTLE  = 3'd2,
    S_DISCARD = 3'd3,
    S_CAPTURE = 3'd4
  } state_t;

  state_t            state, state_nxt;
  logic [SET_W-1:0]  settle_cnt;
  logic [DIS_W-1:0]  discard_cnt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        rr_ptr;
  logic [1:0]        host_axis;
  logic              host_pend;
  logic              slot_host;

  logic              in_wait;
  logic              capture_evt;
  logic              timeout_evt;
  logic              slot_end;
  logic              host_done;
  logic              req_take;
  logic              req_bad;
  logic              host_pend_nxt;
  logic              end_to_select;
  logic [15:0]       axis_cur;
  logic [2:0]        dim_mask;

  // Slot events and host request arbitration.
  always_comb begin
    in_wait     = (state == S_DISCARD) || (state == S_CAPTURE);
    capture_evt = (state == S_CAPTURE) && iSAMPLE_STB;
    timeout_evt = in_wait && (wait_cnt == WAIT_LAST) && !capture_evt;
    slot_end    = capture_evt || timeout_evt;
    host_done   = slot_end && slot_host;
    // A valid request may land on the very cycle the pending one is retired.
    req_take    = iHOST_REQ && (iHOST_AXIS != 2'd3) && (!host_pend || host_done);
    // Invalid-axis requests are answered immediately; only taken when nothing is
    // pending, so their ack can never collide with a slot ack.
    req_bad     = iHOST_REQ && (iHOST_AXIS == 2'd3) && !host_pend;
    host_pend_nxt = req_take || (host_pend && !host_done);
    end_to_select = iEN || host_pend_nxt;
    axis_cur = 16'h0000;
    dim_mask = 3'b000;
    case (oDIMENSION)
      2'd0:    begin axis_cur = oAXIS_X; dim_mask = 3'b001; end
      2'd1:    begin axis_cur = oAXIS_Y; dim_mask = 3'b010; end
      2'd2:    begin axis_cur = oAXIS_Z; dim_mask = 3'b100; end
      default: begin axis_cur = 16'h0000; dim_mask = 3'b000; end
    endcase
  end

  // Next-state logic for the slot sequencer.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (host_pend || iEN) state_nxt = S_SELECT;
      S_SELECT:  state_nxt = S_SETTLE;
      S_SETTLE:  if (settle_cnt == SET_LAST) state_nxt = (DISCARD == 0) ? S_CAPTURE : S_DISCARD;
      S_DISCARD: begin
        if (timeout_evt)                                  state_nxt = end_to_select ? S_SELECT : S_IDLE;
        else if (iSAMPLE_STB && (discard_cnt == DIS_LAST)) state_nxt = S_CAPTURE;
      end
      S_CAPTURE: if (slot_end) state_nxt = end_to_select ? S_SELECT : S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Settle, discard and wait counters; cleared at every slot start, saturating.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      settle_cnt  <= '0;
      discard_cnt <= '0;
      wait_cnt    <= '0;
    end else if (state == S_SELECT) begin
      settle_cnt  <= '0;
      discard_cnt <= '0;
      wait_cnt    <= '0;
    end else begin
      if ((state == S_SETTLE) && (settle_cnt != SET_LAST))
        settle_cnt <= settle_cnt + 1'b1;
      if ((state == S_DISCARD) && iSAMPLE_STB && (discard_cnt != DIS_LAST))
        discard_cnt <= discard_cnt + 1'b1;
      if (in_wait && (wait_cnt != WAIT_LAST))
        wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Host pending flag, target selection and round-robin pointer.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      host_pend  <= 1'b0;
      host_axis  <= 2'd0;
      slot_host  <= 1'b0;
      rr_ptr     <= 2'd0;
      oDIMENSION <= 2'd0;
    end else begin
      host_pend <= host_pend_nxt;
      if (req_take) host_axis <= iHOST_AXIS;
      if (state == S_SELECT) begin
        slot_host  <= host_pend;
        oDIMENSION <= host_pend ? host_axis : rr_ptr;
      end
      // Host-serviced slots leave the round-robin position untouched.
      if (slot_end && !slot_host)
        rr_ptr <= (rr_ptr == 2'd2) ? 2'd0 : rr_ptr + 2'd1;
    end
  end

  // Snapshot bank, fresh flags, host reply and sticky timeout.
  always_ff @(posedge iCLK or negedge iRSTN) begin
    if (!iRSTN) begin
      oAXIS_X    <= 16'h0000;
      oAXIS_Y    <= 16'h0000;
      oAXIS_Z    <= 16'h0000;
      oFRESH     <= 3'b000;
      oHOST_ACK  <= 1'b0;
      oHOST_DATA <= 16'h0000;
      oTIMEOUT   <= 1'b0;
    end else begin
      oHOST_ACK <= 1'b0;
      if (capture_evt) begin
        if (dim_mask[0]) oAXIS_X <= iSAMPLE;
        if (dim_mask[1]) oAXIS_Y <= iSAMPLE;
        if (dim_mask[2]) oAXIS_Z <= iSAMPLE;
      end
      if (timeout_evt) oTIMEOUT <= 1'b1;
      if (slot_end) begin
        if (slot_host)        oFRESH <= oFRESH & ~dim_mask;
        else if (capture_evt) oFRESH <= oFRESH | dim_mask;
      end
      if (host_done) begin
        oHOST_ACK  <= 1'b1;
        oHOST_DATA <= capture_evt ? iSAMPLE : axis_cur;
      end else if (req_bad) begin
        oHOST_ACK  <= 1'b1;
        oHOST_DATA <= 16'h0000;
      end
    end
  end

endmodule

// File: tb/tb_accel_axis_scheduler.sv
// Directed bench for accel_axis_scheduler with SETTLE=4, DISCARD=1, TIMEOUT=64.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_accel_axis_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        host_req = 1'b0;
  logic [1:0]  host_axis = 2'd0;
  logic        man_stb = 1'b0;
  logic [15:0] man_smp = 16'h0000;
  logic        auto_en = 1'b0;
  logic        auto_stb = 1'b0;
  logic [15:0] auto_smp = 16'h0000;
  int          auto_cnt = 0;
  logic        stb_w;
  logic [15:0] smp_w;

  logic [1:0]  dim;
  logic        ack;
  logic [15:0] host_data, ax_x, ax_y, ax_z;
  logic [2:0]  fresh;
  logic        tmo;

  int n_chk = 0;
  int n_err = 0;
  int ack_cnt = 0;
  int hist_n = 0;
  logic [1:0] hist [0:15];
  logic [1:0] dim_prev = 2'd0;

  assign stb_w = auto_en ? auto_stb : man_stb;
  assign smp_w = auto_en ? auto_smp : man_smp;

  accel_axis_scheduler #(.SETTLE_CYCLES(4), .DISCARD(1), .TIMEOUT(64)) dut (
    .iCLK(clk), .iRSTN(rst_n), .iEN(en), .iSAMPLE(smp_w), .iSAMPLE_STB(stb_w),
    .oDIMENSION(dim), .iHOST_REQ(host_req), .iHOST_AXIS(host_axis),
    .oHOST_ACK(ack), .oHOST_DATA(host_data),
    .oAXIS_X(ax_x), .oAXIS_Y(ax_y), .oAXIS_Z(ax_z),
    .oFRESH(fresh), .oTIMEOUT(tmo)
  );

  always #5 clk = ~clk;

  // Periodic strobe source: one strobe every 20 clocks, sample = 0x1000 + axis.
  always @(negedge clk) begin
    if (!auto_en) begin
      auto_cnt = 0;
      auto_stb = 1'b0;
    end else begin
      auto_cnt = auto_cnt + 1;
      if (auto_cnt >= 20) begin
        auto_cnt = 0;
        auto_stb = 1'b1;
        auto_smp = 16'h1000 + {14'd0, dim};
      end else begin
        auto_stb = 1'b0;
      end
    end
  end

  // Ack counter and oDIMENSION change history.
  always @(negedge clk) begin
    if (ack) ack_cnt = ack_cnt + 1;
    if (!rst_n) begin
      hist_n   = 0;
      dim_prev = 2'd0;
    end else if (dim != dim_prev) begin
      if (hist_n < 16) hist[hist_n] = dim;
      hist_n   = hist_n + 1;
      dim_prev = dim;
    end
  end

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; host_req = 1'b0; host_axis = 2'd0;
    man_stb = 1'b0; man_smp = 16'h0000; auto_en = 1'b0;
    tick(3);
    rst_n = 1'b1;
  endtask

  task automatic wait_ack(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (ack) begin ok = 1'b1; break; end
    end
  endtask

  // X slot from an IDLE start (en raised at N0): junk strobe mid-settle, the
  // discard strobe, then the captured strobe; ends at N9.
  task automatic x_slot_seq(input logic [15:0] val, input logic [15:0] prior);
    tick(4); man_smp = 16'hDEAD; man_stb = 1'b1;
    tick(1); man_stb = 1'b0;
    tick(1); man_smp = 16'hBEEF; man_stb = 1'b1;
    tick(1); man_stb = 1'b0;
    chk_eq("x_not_captured_early", ax_x, prior);
    tick(1); man_smp = val; man_stb = 1'b1;
    tick(1); man_stb = 1'b0;
    chk_eq("x_captured", ax_x, val);
    chk_eq("x_fresh", fresh, 3'b001);
  endtask

  initial begin : main
    bit ok;
    int a0;
    int a1;

    // Reset values, invalid-axis request, slot timeout.
    do_reset();
    chk_eq("rst_dim", dim, 2'd0);
    chk_eq("rst_axis_x", ax_x, 16'h0);
    chk_eq("rst_axis_y", ax_y, 16'h0);
    chk_eq("rst_axis_z", ax_z, 16'h0);
    chk_eq("rst_fresh", fresh, 3'b000);
    chk_eq("rst_ack", ack, 1'b0);
    chk_eq("rst_host_data", host_data, 16'h0);
    chk_eq("rst_timeout", tmo, 1'b0);
    en = 1'b1;
    tick(10); host_req = 1'b1; host_axis = 2'd3;
    tick(1);  host_req = 1'b0;
    chk_eq("bad_axis_ack", ack, 1'b1);
    chk_eq("bad_axis_data", host_data, 16'h0);
    tick(1);
    chk_eq("bad_axis_ack_width", ack, 1'b0);
    tick(57);
    chk_eq("timeout_not_yet", tmo, 1'b0);
    tick(1);
    chk_eq("timeout_at_64", tmo, 1'b1);
    chk_eq("timeout_dim_hold", dim, 2'd0);
    tick(1);
    chk_eq("timeout_dim_adv", dim, 2'd1);
    chk_eq("timeout_x_unchanged", ax_x, 16'h0);
    chk_eq("timeout_no_fresh", fresh, 3'b000);

    // Settle and discard filtering, then reset during CAPTURE.
    do_reset();
    en = 1'b1;
    x_slot_seq(16'h1234, 16'h0000);
    tick(1);
    chk_eq("y_slot_dim", dim, 2'd1);
    tick(4); man_smp = 16'h7777; man_stb = 1'b1;
    tick(1); man_stb = 1'b0;
    chk_eq("pre_rst_x", ax_x, 16'h1234);
    chk_eq("pre_rst_y_discarded", ax_y, 16'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("arst_dim", dim, 2'd0);
    chk_eq("arst_axis_x", ax_x, 16'h0);
    chk_eq("arst_fresh", fresh, 3'b000);
    chk_eq("arst_ack", ack, 1'b0);
    chk_eq("arst_timeout", tmo, 1'b0);
    do_reset();
    en = 1'b1;
    x_slot_seq(16'h5A5A, 16'h0000);
    chk_eq("restart_y_untouched", ax_y, 16'h0);

    // Round-robin with periodic strobes, host pre-emption, dropped second request.
    do_reset();
    en = 1'b1; auto_en = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (fresh == 3'b111) begin ok = 1'b1; break; end
    end
    chk_eq("rr_fill_in_time", ok, 1'b1);
    chk_eq("rr_axis_x", ax_x, 16'h1000);
    chk_eq("rr_axis_y", ax_y, 16'h1001);
    chk_eq("rr_axis_z", ax_z, 16'h1002);
    tick(3);
    chk_eq("rr_hist_len", (hist_n >= 3), 1'b1);
    chk_eq("rr_hist0", hist[0], 2'd1);
    chk_eq("rr_hist1", hist[1], 2'd2);
    chk_eq("rr_hist2", hist[2], 2'd0);

    host_req = 1'b1; host_axis = 2'd2;
    tick(1); host_req = 1'b0;
    a0 = ack_cnt;
    wait_ack(200, ok);
    chk_eq("host_z_ack_seen", ok, 1'b1);
    chk_eq("host_z_data", host_data, 16'h1002);
    chk_eq("host_z_fresh", fresh, 3'b011);
    tick(1);
    chk_eq("host_z_ack_width", ack, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (hist_n >= 5) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk_eq("host_hist_len", ok, 1'b1);
    chk_eq("host_preempt_z", hist[3], 2'd2);
    chk_eq("rr_resume_y", hist[4], 2'd1);
    chk_eq("host_z_one_ack", ack_cnt - a0, 1);

    tick(1); host_req = 1'b1; host_axis = 2'd3;
    tick(1); host_req = 1'b0;
    chk_eq("bad_axis2_ack", ack, 1'b1);
    chk_eq("bad_axis2_data", host_data, 16'h0);
    tick(1);
    chk_eq("bad_axis2_ack_width", ack, 1'b0);
    a1 = ack_cnt;
    host_req = 1'b1; host_axis = 2'd0;
    tick(1); host_axis = 2'd1;
    tick(1); host_req = 1'b0;
    wait_ack(200, ok);
    chk_eq("host_x_ack_seen", ok, 1'b1);
    chk_eq("host_x_data", host_data, 16'h1000);
    tick(150);
    chk_eq("second_req_dropped", ack_cnt - a1, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
